// File: rtl/norm_sq_to_float_if.sv
// Sample and result bus for norm_sq_to_float: enable/in_valid/in_re/in_im in, odata/out_valid/sample_idx out.
// The master modport drives samples; the slave modport is the accumulator/converter.
interface norm_sq_to_float_if #(
    parameter int I_DATA  = 16,
    parameter int VEC_LEN = 4,
    parameter int O_DATA  = 32
);
    localparam int IDX_W = $clog2(VEC_LEN);

    logic                     enable;
    logic                     in_valid;
    logic signed [I_DATA-1:0] in_re;
    logic signed [I_DATA-1:0] in_im;
    logic [O_DATA-1:0]        odata;
    logic                     out_valid;
    logic [IDX_W-1:0]         sample_idx;

    modport master (
        output enable, in_valid, in_re, in_im,
        input  odata, out_valid, sample_idx
    );

    modport slave (
        input  enable, in_valid, in_re, in_im,
        output odata, out_valid, sample_idx
    );
endinterface

// File: rtl/norm_sq_to_float.sv
// Purpose: accumulates sum(re^2+im^2) over a VEC_LEN column and emits it as float32 (NORM_SQ_ROUND_EN: RNE rounding, else truncate).
// Latency: out_valid rises 3 enabled edges after the edge accepting a column's last sample.
// Backpressure: none; one sample per cycle, enable=0 freezes every register and masks out_valid.
module norm_sq_to_float #(
    parameter int I_DATA  = 16,
    parameter int VEC_LEN = 4,
    parameter int O_DATA  = 32
) (
    input logic               clk,
    input logic               reset,
    norm_sq_to_float_if.slave bus
);
    localparam int IDX_W = $clog2(VEC_LEN);
    localparam int SQ_W  = 2 * I_DATA;
    localparam int ACC_W = SQ_W + IDX_W;
    localparam int P_W   = $clog2(ACC_W);
    localparam int EXT_W = ACC_W + 25;

    typedef struct packed {
        logic [7:0]  exp;
        logic [22:0] mant;
`ifdef NORM_SQ_ROUND_EN
        logic        guard;
        logic        sticky;
`endif
    } norm_t;

    logic                   accept;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   idx_last;
    logic signed [SQ_W-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [SQ_W-1:0]        sq_q, sq_d;
    logic                   s1_vld_q, s1_last_q, s1_first_q;
    logic [ACC_W-1:0]       acc_q, acc_d, conv_q;
    logic                   conv_vld_q;
    logic [P_W-1:0]         msb_pos;
    logic [EXT_W-1:0]       ext;
    norm_t                  norm_q, norm_d;
    logic                   norm_vld_q;
    logic [O_DATA-1:0]      odata_q, odata_d;
    logic                   out_vld_q;

    assign accept = bus.enable & bus.in_valid;

    always_comb begin
        idx_last = (idx_q == IDX_W'(VEC_LEN - 1));
        idx_d    = idx_last ? '0 : idx_q + 1'b1;
        re_ext   = SQ_W'(bus.in_re);
        im_ext   = SQ_W'(bus.in_im);
        re_sq    = re_ext * re_ext;
        im_sq    = im_ext * im_ext;
        sq_d     = $unsigned(re_sq) + $unsigned(im_sq);
        // The first sample of a column overwrites the sum, so no clear cycle is needed.
        acc_d    = s1_first_q ? ACC_W'(sq_q) : acc_q + ACC_W'(sq_q);
    end

    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (conv_q[i]) msb_pos = P_W'(i);
        end
        // Park the leading one at the top bit; the 23 bits under it are the mantissa.
        ext         = {conv_q, 25'b0} << (P_W'(ACC_W - 1) - msb_pos);
        norm_d      = '0;
        norm_d.exp  = (conv_q == '0) ? 8'd0 : 8'd127 + 8'(msb_pos);
        norm_d.mant = ext[EXT_W-2 -: 23];
`ifdef NORM_SQ_ROUND_EN
        norm_d.guard  = ext[EXT_W-25];
        norm_d.sticky = |ext[EXT_W-26:0];
`endif
    end

`ifdef NORM_SQ_ROUND_EN
    logic        rnd_up, mant_carry;
    logic [22:0] mant_r;
    always_comb begin
        rnd_up                 = norm_q.guard & (norm_q.sticky | norm_q.mant[0]);
        {mant_carry, mant_r}   = {1'b0, norm_q.mant} + 24'(rnd_up);
        odata_d                = O_DATA'({1'b0, norm_q.exp + 8'(mant_carry), mant_r});
    end
`else
    always_comb begin
        odata_d = O_DATA'({1'b0, norm_q.exp, norm_q.mant});
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q      <= '0;
            sq_q       <= '0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_first_q <= 1'b0;
            acc_q      <= '0;
            conv_q     <= '0;
            conv_vld_q <= 1'b0;
            norm_q     <= '0;
            norm_vld_q <= 1'b0;
            odata_q    <= '0;
            out_vld_q  <= 1'b0;
        end else if (bus.enable) begin
            s1_vld_q <= accept;
            if (accept) begin
                sq_q       <= sq_d;
                s1_last_q  <= idx_last;
                s1_first_q <= (idx_q == '0);
                idx_q      <= idx_d;
            end
            conv_vld_q <= s1_vld_q & s1_last_q;
            if (s1_vld_q) acc_q <= acc_d;
            if (s1_vld_q & s1_last_q) conv_q <= acc_d;
            norm_vld_q <= conv_vld_q;
            if (conv_vld_q) norm_q <= norm_d;
            out_vld_q <= norm_vld_q;
            if (norm_vld_q) odata_q <= odata_d;
        end
    end

    assign bus.odata      = odata_q;
    assign bus.out_valid  = out_vld_q & bus.enable;
    assign bus.sample_idx = idx_q;
endmodule

// File: tb/tb_norm_sq_to_float.sv
// Bench for norm_sq_to_float: directed column vectors, back-to-back, stalls, mid-column reset, random columns vs float model.
module tb_norm_sq_to_float;
    localparam int I_DATA  = 16;
    localparam int VEC_LEN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    norm_sq_to_float_if #(.I_DATA(I_DATA), .VEC_LEN(VEC_LEN), .O_DATA(32)) bus ();

    norm_sq_to_float #(.I_DATA(I_DATA), .VEC_LEN(VEC_LEN), .O_DATA(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int stall_strobe = 0;
    logic [31:0] obs_val[$];
    int          obs_cyc[$];

    int d_re [5][4] = '{'{1, 0, 0, 0}, '{1, 1, 1, 1}, '{0, 0, 0, 0},
                        '{-32768, -32768, -32768, -32768}, '{4096, 1, 1, 0}};
    int d_im [5][4] = '{'{0, 0, 0, 0}, '{1, 1, 1, 1}, '{0, 0, 0, 0},
                        '{-32768, -32768, -32768, -32768}, '{0, 1, 0, 0}};
`ifdef NORM_SQ_ROUND_EN
    logic [31:0] d_exp [5] = '{32'h3F80_0000, 32'h4100_0000, 32'h0000_0000, 32'h5000_0000, 32'h4B80_0002};
`else
    logic [31:0] d_exp [5] = '{32'h3F80_0000, 32'h4100_0000, 32'h0000_0000, 32'h5000_0000, 32'h4B80_0001};
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            obs_val.push_back(bus.odata);
            obs_cyc.push_back(cyc);
            if (bus.enable !== 1'b1) stall_strobe++;
        end
    end

    // Float32 value of an unsigned integer from plain arithmetic.
    function automatic logic [31:0] model(input longint s);
        longint q;
        int     p;
`ifdef NORM_SQ_ROUND_EN
        longint rem, half;
`endif
        if (s == 0) return 32'h0;
        p = 0;
        while ((s >> (p + 1)) != 0) p++;
        if (p >= 23) q = s >> (p - 23);
        else         q = s << (23 - p);
`ifdef NORM_SQ_ROUND_EN
        if (p >= 24) begin
            rem  = s - (q << (p - 23));
            half = longint'(1) << (p - 24);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = longint'(1) << 23;
                p++;
            end
        end
`endif
        return {1'b0, 8'(127 + p), q[22:0]};
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 8)) - 4;
            1:       return int'($urandom_range(0, 65535)) - 32768;
            2:       return -32768;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic drive(input logic v, input logic en, input int re, input int im);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.enable   = en;
        bus.in_re    = 16'(re);
        bus.in_im    = 16'(im);
        if (v && en) last_acc = cyc + 1;
    endtask

    task automatic send(input int re, input int im);
        drive(1'b1, 1'b1, re, im);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 0, 0);
    endtask

    task automatic clear_obs();
        obs_val.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.odata !== 32'h0) $display("FAIL reset_odata: got %h expected %h", bus.odata, 32'h0);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.sample_idx !== 2'd0) $display("FAIL reset_sample_idx: got %0d expected 0", bus.sample_idx);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        idle(2);
        n_checks++;
        if (obs_val.size() != 0) $display("FAIL reset_no_strobe: got %0d strobes expected 0", obs_val.size());
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] got;
        int          gcyc;
        for (int c = 0; c < 5; c++) begin
            clear_obs();
            for (int s = 0; s < 4; s++) send(d_re[c][s], d_im[c][s]);
            idle(6);
            got  = (obs_val.size() > 0) ? obs_val[0] : 32'hxxxx_xxxx;
            gcyc = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
            n_checks++;
            if (obs_val.size() != 1) $display("FAIL dir%0d_count: got %0d strobes expected 1", c, obs_val.size());
            else n_pass++;
            n_checks++;
            if (got !== d_exp[c]) $display("FAIL dir%0d_value: got %h expected %h", c, got, d_exp[c]);
            else n_pass++;
            n_checks++;
            if (gcyc != last_acc + 3) $display("FAIL dir%0d_latency: got cycle %0d expected %0d", c, gcyc, last_acc + 3);
            else n_pass++;
            n_checks++;
            if (bus.odata !== d_exp[c]) $display("FAIL dir%0d_hold: got %h expected %h", c, bus.odata, d_exp[c]);
            else n_pass++;
            n_checks++;
            if (bus.sample_idx !== 2'd0) $display("FAIL dir%0d_idx: got %0d expected 0", c, bus.sample_idx);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        repeat (4) send(1, 1);
        repeat (4) send(1, 0);
        idle(8);
        n_checks++;
        if (obs_val.size() != 2) $display("FAIL b2b_count: got %0d strobes expected 2", obs_val.size());
        else n_pass++;
        if (obs_val.size() == 2) begin
            n_checks++;
            if (obs_val[0] !== 32'h4100_0000) $display("FAIL b2b_val0: got %h expected %h", obs_val[0], 32'h4100_0000);
            else n_pass++;
            n_checks++;
            if (obs_val[1] !== 32'h4080_0000) $display("FAIL b2b_val1: got %h expected %h", obs_val[1], 32'h4080_0000);
            else n_pass++;
            n_checks++;
            if (obs_cyc[1] - obs_cyc[0] != 4) $display("FAIL b2b_spacing: got %0d expected 4", obs_cyc[1] - obs_cyc[0]);
            else n_pass++;
            n_checks++;
            if (obs_cyc[1] != last_acc + 3) $display("FAIL b2b_latency: got %0d expected %0d", obs_cyc[1], last_acc + 3);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int first_acc;
        int acc_a;
        clear_obs();
        send(1, 1);
        first_acc = last_acc;
        send(1, 1);
        repeat (3) drive(1'b1, 1'b0, 7, 7);
        n_checks++;
        if (bus.sample_idx !== 2'd2) $display("FAIL stall_idx_hold: got %0d expected 2", bus.sample_idx);
        else n_pass++;
        send(1, 1);
        send(1, 1);
        repeat (4) send(1, 0);
        idle(8);
        n_checks++;
        if (obs_val.size() != 2) $display("FAIL stall_count: got %0d strobes expected 2", obs_val.size());
        else n_pass++;
        if (obs_val.size() == 2) begin
            n_checks++;
            if (obs_val[0] !== 32'h4100_0000 || obs_val[1] !== 32'h4080_0000)
                $display("FAIL stall_values: got %h,%h expected 41000000,40800000", obs_val[0], obs_val[1]);
            else n_pass++;
            n_checks++;
            if (obs_cyc[0] != first_acc + 9) $display("FAIL stall_delay: got %0d expected %0d", obs_cyc[0], first_acc + 9);
            else n_pass++;
            n_checks++;
            if (obs_cyc[1] - obs_cyc[0] != 4) $display("FAIL stall_spacing: got %0d expected 4", obs_cyc[1] - obs_cyc[0]);
            else n_pass++;
        end
        // Freeze while the strobe is already registered: it must appear once on resume.
        clear_obs();
        repeat (4) send(2, 0);
        acc_a = last_acc;
        idle(2);
        repeat (3) drive(1'b0, 1'b0, 0, 0);
        idle(6);
        n_checks++;
        if (obs_val.size() != 1 || obs_cyc[0] != acc_a + 6 || obs_val[0] !== 32'h4180_0000)
            $display("FAIL stall_pending: got %0d strobes (first cycle %0d) expected 1 at %0d value 41800000",
                     obs_val.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, acc_a + 6);
        else n_pass++;
        n_checks++;
        if (stall_strobe != 0) $display("FAIL stall_masked: got %0d strobes with enable=0 expected 0", stall_strobe);
        else n_pass++;
    endtask

    task automatic test_reset_mid_column();
        clear_obs();
        send(5, 5);
        send(5, 5);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.sample_idx !== 2'd0) $display("FAIL rstmid_idx: got %0d expected 0", bus.sample_idx);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) send(1, 1);
        idle(8);
        n_checks++;
        if (obs_val.size() != 1) $display("FAIL rstmid_count: got %0d strobes expected 1", obs_val.size());
        else n_pass++;
        n_checks++;
        if (bus.odata !== 32'h4100_0000) $display("FAIL rstmid_value: got %h expected %h", bus.odata, 32'h4100_0000);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        longint      sum;
        int          re, im;
        clear_obs();
        for (int c = 0; c < 40; c++) begin
            sum = 0;
            for (int s = 0; s < 4; s++) begin
                while ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) drive(1'b0, 1'b1, 0, 0);
                    else drive(1'($urandom_range(0, 1)), 1'b0, rnd_val(), rnd_val());
                end
                re = rnd_val();
                im = rnd_val();
                sum += longint'(re) * re + longint'(im) * im;
                send(re, im);
            end
            exp_q.push_back(model(sum));
        end
        idle(8);
        n_checks++;
        if (obs_val.size() != exp_q.size()) $display("FAIL rand_count: got %0d strobes expected %0d", obs_val.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_val.size(); i++) begin
            n_checks++;
            if (obs_val[i] !== exp_q[i]) $display("FAIL rand_col%0d: got %h expected %h", i, obs_val[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (stall_strobe != 0) $display("FAIL rand_masked: got %0d strobes with enable=0 expected 0", stall_strobe);
        else n_pass++;
    endtask

    initial begin
        bus.enable   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid_column();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
